// File: rtl/pipeline_stage_decode.sv
// Decode stage: field extraction, register file, load-use stall
// and epoch-based squashing of wrong-path instructions.
module pipeline_stage_decode (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fetchPc,
    input  logic        fetchEpoch,
    input  logic [31:0] fetchInstruction,
    input  logic        jumpEnabled,
    input  logic        wbEnable,
    input  logic [4:0]  wbIndex,
    input  logic [31:0] wbValue,
    output logic        stallOnDecode,
    output logic        decValid,
    output logic [31:0] decPc,
    output logic [31:0] decRsValue,
    output logic [31:0] decRtValue,
    output logic [31:0] decImm,
    output logic [4:0]  decDest,
    output logic        decRegWrite,
    output logic        decIsLoad,
    output logic        decIsStore,
    output logic        decIsBranch,
    output logic [5:0]  decOpcode,
    output logic [5:0]  decFunct
);

    logic [31:0] rf_q [32];
    logic        epoch_q;

    logic        valid_q, valid_d;
    logic [31:0] pc_q, rsv_q, rtv_q, imm_q;
    logic [31:0] rsv_d, rtv_d, imm_d;
    logic [4:0]  dest_q, dest_d;
    logic        wr_q, wr_d, ld_q, ld_d, st_q, st_d, br_q, br_d;
    logic [5:0]  op_q, fn_q;

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic        wr_c, ld_c, st_c, br_c, reads_rt;
    logic        live, hazard;

    assign op  = fetchInstruction[31:26];
    assign rs  = fetchInstruction[25:21];
    assign rt  = fetchInstruction[20:16];
    assign rd  = fetchInstruction[15:11];
    assign fn  = fetchInstruction[5:0];
    assign imm = fetchInstruction[15:0];

    // Classify the opcode; no-write instructions carry dest 0
    always_comb begin
        dest_d   = rt;
        wr_c     = 1'b1;
        ld_c     = 1'b0;
        st_c     = 1'b0;
        br_c     = 1'b0;
        reads_rt = 1'b0;
        case (op)
            6'h00: begin
                dest_d   = rd;
                reads_rt = 1'b1;
            end
            6'h23: ld_c = 1'b1;
            6'h2B: begin
                st_c     = 1'b1;
                wr_c     = 1'b0;
                dest_d   = 5'd0;
                reads_rt = 1'b1;
            end
            6'h04, 6'h05: begin
                br_c     = 1'b1;
                wr_c     = 1'b0;
                dest_d   = 5'd0;
                reads_rt = 1'b1;
            end
            default: ;
        endcase
    end

    // Register reads with same-cycle writeback bypass; r0 is hardwired
    always_comb begin
        rsv_d = rf_q[rs];
        rtv_d = rf_q[rt];
        if (wbEnable && wbIndex == rs) rsv_d = wbValue;
        if (wbEnable && wbIndex == rt) rtv_d = wbValue;
        if (rs == 5'd0) rsv_d = 32'd0;
        if (rt == 5'd0) rtv_d = 32'd0;
    end

    assign imm_d = {{16{imm[15]}}, imm};

    assign live = (fetchEpoch == epoch_q) && !jumpEnabled;

    assign hazard = live && valid_q && ld_q && (dest_q != 5'd0)
                    && ((dest_q == rs) || (reads_rt && dest_q == rt));

    assign stallOnDecode = hazard && !reset;

    // Issue only live, hazard-free instructions; otherwise a bubble
    always_comb begin
        valid_d = live && !hazard;
        wr_d    = valid_d && wr_c && (dest_d != 5'd0);
        ld_d    = valid_d && ld_c;
        st_d    = valid_d && st_c;
        br_d    = valid_d && br_c;
    end

    // Register file: single-cycle clear, r0 never written
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else if (wbEnable && wbIndex != 5'd0) begin
            rf_q[wbIndex] <= wbValue;
        end
    end

    // Expected epoch flips after every redirect
    always_ff @(posedge clock) begin
        if (reset) epoch_q <= 1'b0;
        else if (jumpEnabled) epoch_q <= ~epoch_q;
    end

    // Decode result register; bubbles still carry the PC
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= 32'd0;
            rsv_q   <= 32'd0;
            rtv_q   <= 32'd0;
            imm_q   <= 32'd0;
            dest_q  <= 5'd0;
            wr_q    <= 1'b0;
            ld_q    <= 1'b0;
            st_q    <= 1'b0;
            br_q    <= 1'b0;
            op_q    <= 6'd0;
            fn_q    <= 6'd0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= fetchPc;
            rsv_q   <= rsv_d;
            rtv_q   <= rtv_d;
            imm_q   <= imm_d;
            dest_q  <= dest_d;
            wr_q    <= wr_d;
            ld_q    <= ld_d;
            st_q    <= st_d;
            br_q    <= br_d;
            op_q    <= op;
            fn_q    <= fn;
        end
    end

    assign decValid    = valid_q;
    assign decPc       = pc_q;
    assign decRsValue  = rsv_q;
    assign decRtValue  = rtv_q;
    assign decImm      = imm_q;
    assign decDest     = dest_q;
    assign decRegWrite = wr_q;
    assign decIsLoad   = ld_q;
    assign decIsStore  = st_q;
    assign decIsBranch = br_q;
    assign decOpcode   = op_q;
    assign decFunct    = fn_q;

endmodule

// File: tb/tb_pipeline_stage_decode.sv
// Bench for pipeline_stage_decode: directed scenarios followed by
// random traffic compared against a behavioural decode model.
module tb_pipeline_stage_decode;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] fetchPc;
    logic        fetchEpoch;
    logic [31:0] fetchInstruction;
    logic        jumpEnabled;
    logic        wbEnable;
    logic [4:0]  wbIndex;
    logic [31:0] wbValue;
    logic        stallOnDecode;
    logic        decValid;
    logic [31:0] decPc, decRsValue, decRtValue, decImm;
    logic [4:0]  decDest;
    logic        decRegWrite, decIsLoad, decIsStore, decIsBranch;
    logic [5:0]  decOpcode, decFunct;

    pipeline_stage_decode dut (
        .clock(clock), .reset(reset),
        .fetchPc(fetchPc), .fetchEpoch(fetchEpoch),
        .fetchInstruction(fetchInstruction),
        .jumpEnabled(jumpEnabled),
        .wbEnable(wbEnable), .wbIndex(wbIndex), .wbValue(wbValue),
        .stallOnDecode(stallOnDecode),
        .decValid(decValid), .decPc(decPc),
        .decRsValue(decRsValue), .decRtValue(decRtValue),
        .decImm(decImm), .decDest(decDest),
        .decRegWrite(decRegWrite), .decIsLoad(decIsLoad),
        .decIsStore(decIsStore), .decIsBranch(decIsBranch),
        .decOpcode(decOpcode), .decFunct(decFunct)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int fails  = 0;

    // reference model state
    logic [31:0] m_rf [32];
    logic        m_ep;
    logic        m_valid, m_load;
    logic [4:0]  m_dest;
    logic        m_stall;
    logic        obs_stall;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input logic [31:0] pc,
                        input bit ep, input logic [31:0] ins,
                        input bit jmp, input bit we,
                        input logic [4:0] wi, input logic [31:0] wv);
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        bit          live, rdrt, nowr, isr, ev;
        logic [31:0] ersv, ertv;
        logic [4:0]  edest;
        reset = rst; fetchPc = pc; fetchEpoch = ep;
        fetchInstruction = ins; jumpEnabled = jmp;
        wbEnable = we; wbIndex = wi; wbValue = wv;
        op = ins[31:26]; rs = ins[25:21];
        rt = ins[20:16]; rd = ins[15:11];
        isr  = (op == 6'h00);
        nowr = (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
        rdrt = isr || nowr;
        edest = isr ? rd : (nowr ? 5'd0 : rt);
        live = (ep == m_ep) && !jmp;
        m_stall = !rst && live && m_valid && m_load && m_dest != 0
                  && (m_dest == rs || (rdrt && m_dest == rt));
        ev = !rst && live && !m_stall;
        ersv = (rs == 0) ? 32'd0 :
               ((we && wi == rs) ? wv : m_rf[rs]);
        ertv = (rt == 0) ? 32'd0 :
               ((we && wi == rt) ? wv : m_rf[rt]);
        #1;
        obs_stall = stallOnDecode;
        chk("stall", {31'd0, stallOnDecode}, {31'd0, m_stall});
        if (rst) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
            m_ep = 1'b0;
        end else begin
            if (we && wi != 0) m_rf[wi] = wv;
            if (jmp) m_ep = ~m_ep;
        end
        m_valid = ev;
        m_load  = ev && (op == 6'h23);
        m_dest  = edest;
        @(posedge clock);
        #1;
        chk("valid", {31'd0, decValid}, {31'd0, ev});
        chk("pc", decPc, rst ? 32'd0 : pc);
        chk("regwrite", {31'd0, decRegWrite},
            {31'd0, ev && !nowr && edest != 0});
        chk("isload", {31'd0, decIsLoad}, {31'd0, ev && op == 6'h23});
        chk("isstore", {31'd0, decIsStore}, {31'd0, ev && op == 6'h2B});
        chk("isbranch", {31'd0, decIsBranch},
            {31'd0, ev && (op == 6'h04 || op == 6'h05)});
        if (ev) begin
            chk("rsval", decRsValue, ersv);
            chk("rtval", decRtValue, ertv);
            chk("imm", decImm, 32'(signed'(ins[15:0])));
            chk("opcode", {26'd0, decOpcode}, {26'd0, op});
            chk("funct", {26'd0, decFunct}, {26'd0, ins[5:0]});
            if (!nowr) chk("dest", {27'd0, decDest}, {27'd0, edest});
        end
    endtask

    localparam logic [31:0] ADD7 = 32'h00A6_3820;
    localparam logic [31:0] LW8  = 32'h8C28_0004;
    localparam logic [31:0] ADD9 = 32'h0102_4820;

    logic [5:0]  ops [7];
    logic [31:0] r_ins, r_pc, rnd;
    logic [5:0]  r_op;

    initial begin
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0D};
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_ep = 0; m_valid = 0; m_load = 0; m_dest = 0; m_stall = 0;

        step(1, 32'h0, 0, 32'h0, 1, 1, 5'd3, 32'h55);
        step(1, 32'h0, 0, 32'h0, 0, 0, 5'd0, 32'h0);
        chk("reset_valid", {31'd0, decValid}, 32'd0);
        chk("reset_pc", decPc, 32'd0);

        step(0, 32'h100, 0, 32'h0, 0, 1, 5'd5, 32'h1234);
        step(0, 32'h104, 0, ADD7, 0, 0, 5'd0, 32'h0);
        chk("add_valid", {31'd0, decValid}, 32'd1);
        chk("add_rs", decRsValue, 32'h1234);
        chk("add_dest", {27'd0, decDest}, 32'd7);
        chk("add_wr", {31'd0, decRegWrite}, 32'd1);

        step(0, 32'h108, 0, LW8, 0, 0, 5'd0, 32'h0);
        step(0, 32'h10C, 0, ADD9, 0, 0, 5'd0, 32'h0);
        chk("lu_stall", {31'd0, obs_stall}, 32'd1);
        chk("lu_bubble", {31'd0, decValid}, 32'd0);
        chk("lu_bubble_pc", decPc, 32'h10C);
        step(0, 32'h10C, 0, ADD9, 0, 0, 5'd0, 32'h0);
        chk("lu_restall", {31'd0, obs_stall}, 32'd0);
        chk("lu_issue", {31'd0, decValid}, 32'd1);

        step(0, 32'h110, 0, LW8, 0, 0, 5'd0, 32'h0);
        step(0, 32'h114, 0, ADD9, 1, 0, 5'd0, 32'h0);
        chk("jmp_stall", {31'd0, obs_stall}, 32'd0);
        chk("jmp_bubble", {31'd0, decValid}, 32'd0);
        step(0, 32'h118, 0, ADD7, 0, 0, 5'd0, 32'h0);
        chk("stale1", {31'd0, decValid}, 32'd0);
        step(0, 32'h11C, 0, ADD7, 0, 0, 5'd0, 32'h0);
        chk("stale2", {31'd0, decValid}, 32'd0);
        step(0, 32'h200, 1, ADD7, 0, 0, 5'd0, 32'h0);
        chk("epoch1", {31'd0, decValid}, 32'd1);

        step(0, 32'h204, 1, 32'h2064_0005, 0, 1, 5'd3, 32'hDEAD_BEEF);
        chk("bypass", decRsValue, 32'hDEAD_BEEF);

        step(0, 32'h208, 1, 32'h0, 0, 1, 5'd0, 32'hFFFF_FFFF);
        step(0, 32'h20C, 1, 32'h2001_0007, 0, 0, 5'd0, 32'h0);
        chk("r0_read", decRsValue, 32'd0);
        step(0, 32'h210, 1, 32'h00A6_0020, 0, 0, 5'd0, 32'h0);
        chk("rd0_valid", {31'd0, decValid}, 32'd1);
        chk("rd0_wr", {31'd0, decRegWrite}, 32'd0);

        step(0, 32'h214, 1, LW8, 0, 0, 5'd0, 32'h0);
        step(1, 32'h218, 1, ADD9, 1, 1, 5'd8, 32'h77);
        chk("rst_stall", {31'd0, obs_stall}, 32'd0);
        chk("rst_valid", {31'd0, decValid}, 32'd0);
        step(0, 32'h300, 0, ADD9, 0, 0, 5'd0, 32'h0);
        chk("rst_live", {31'd0, decValid}, 32'd1);
        chk("rst_r8", decRsValue, 32'd0);
        step(0, 32'h304, 0, ADD7, 0, 0, 5'd0, 32'h0);
        chk("rst_r5", decRsValue, 32'd0);
        chk("rst_r6", decRtValue, 32'd0);

        r_pc = 32'h400;
        r_ins = 32'h0;
        for (int n = 0; n < 400; n++) begin
            if (!m_stall) begin
                r_op = ops[$urandom_range(0, 6)];
                rnd = $urandom();
                r_ins = {r_op, 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)), rnd[10:0]};
                r_pc = r_pc + 32'd4;
            end
            step($urandom_range(0, 49) == 0, r_pc,
                 ($urandom_range(0, 5) == 0) ? ~m_ep : m_ep,
                 r_ins, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 7)), $urandom());
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_stage_decode.md
PIPELINE_STAGE_DECODE -- requirements
Module: pipeline_stage_decode

Interface
REQ-001 clock  in  1  system clock; all state updates on posedge clock.
REQ-002 reset  in  1  synchronous, active-high.
REQ-003 fetchPc  in  32  PC of the instruction held in the fetch result register.
REQ-004 fetchEpoch  in  1  programCounterChangedTimes tag from fetch; toggles on every taken jump.
REQ-005 fetchInstruction  in  32  raw instruction word from fetch.
REQ-006 jumpEnabled  in  1  execute stage redirects the PC this cycle.
REQ-007 wbEnable / wbIndex / wbValue  in  1/5/32  register-file write port from writeback.
REQ-008 stallOnDecode  out  1  combinational; freezes fetch this cycle.
REQ-009 decValid, decPc[32], decRsValue[32], decRtValue[32], decImm[32], decDest[5], decRegWrite, decIsLoad, decIsStore, decIsBranch, decOpcode[6], decFunct[6]  out  registered decode result.

Function
REQ-010 Fields SHALL be: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0], imm [15:0].
REQ-011 decImm SHALL be imm sign-extended to 32 bits.
REQ-012 Classification: opcode 0x00 -> dest rd, regWrite=1; 0x23 -> dest rt, regWrite=1, isLoad=1; 0x2B -> isStore=1, regWrite=0; 0x04/0x05 -> isBranch=1, regWrite=0; all others -> dest rt, regWrite=1.
REQ-013 Any instruction whose dest is register 0 SHALL output decRegWrite=0.
REQ-014 An internal 32x32 register file SHALL be written on posedge clock when wbEnable=1 and wbIndex!=0; register 0 SHALL always read 0.
REQ-015 Read with wbEnable=1 and wbIndex equal to rs/rt (nonzero) in the same cycle SHALL return wbValue (write-through bypass).
REQ-016 The block SHALL keep a 1-bit expectedEpoch register; it toggles on the posedge following any cycle with jumpEnabled=1.
REQ-017 An incoming instruction is live iff fetchEpoch==expectedEpoch and jumpEnabled=0.
REQ-018 Load-use hazard: live instruction, current decValid=1, decIsLoad=1, decDest!=0, and decDest equals rs, or equals rt when the opcode reads rt (0x00, 0x2B, 0x04, 0x05).
REQ-019 stallOnDecode SHALL be 1 exactly when a load-use hazard exists; otherwise 0.
REQ-020 On hazard, the next decode result SHALL be a bubble (decValid=0, decRegWrite=0, decIsLoad=0, decIsStore=0, decIsBranch=0); the same instruction is re-presented next cycle and SHALL then decode normally.
REQ-021 Non-live instructions SHALL produce a bubble and SHALL NOT assert stallOnDecode.
REQ-022 jumpEnabled has priority over the hazard: with jumpEnabled=1, stallOnDecode=0 and the output is a bubble.
REQ-023 A live instruction without hazard SHALL produce a decode result with decValid=1 one cycle later (latency 1).
REQ-024 Register values SHALL be sampled in the cycle of decode and held in the output register; later writes do not alter an issued result.
REQ-025 Bubble outputs SHALL still carry decPc = fetchPc for debug tracing.

Reset
REQ-026 With reset=1 at posedge: expectedEpoch=0, decValid=0, all control outputs 0, data outputs 0; stallOnDecode=0 while reset is high.
REQ-027 Register file contents SHALL be cleared to 0 by reset (32-cycle clear not allowed; single-cycle clear).
REQ-028 Reset SHALL override simultaneous wbEnable and jumpEnabled; the first post-reset instruction is live only if fetchEpoch=0.

Verification
REQ-029 Write r5=0x0000_1234 via wb, then decode 0x00A6_3820 (add r7,r5,r6) -> next cycle decValid=1, decRsValue=0x1234, decDest=7, decRegWrite=1.
REQ-030 Decode lw r8,4(r1) then add r9,r8,r2 -> stallOnDecode=1 one cycle, bubble emitted, add decoded the following cycle with decValid=1.
REQ-031 jumpEnabled=1 with a hazard present -> stallOnDecode=0, bubble; next two instructions with stale epoch 0 -> bubbles; first with epoch 1 -> decValid=1.
REQ-032 wbEnable=1, wbIndex=3, wbValue=0xDEAD_BEEF same cycle as decode reading rs=3 -> decRsValue=0xDEADBEEF.
REQ-033 Write to r0 with 0xFFFF_FFFF, then read rs=0 -> decRsValue=0; instruction with rd=0 -> decRegWrite=0.
REQ-034 Assert reset mid-stall -> next cycle decValid=0, stallOnDecode=0, expectedEpoch=0, all registers read 0.
